// File: rtl/cpu_ram_arbiter_pkg.sv
// ============================================================================
// cpu_ram_arbiter_pkg : shared types and widths for the CPU/DMA RAM arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package cpu_ram_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;
   localparam int CNT_W  = 4;

   typedef enum logic [0:0] {
      OWNER_CPU = 1'b0,
      OWNER_DMA = 1'b1
   } e_ram_owner;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } e_arb_state;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                input logic [CNT_W-1:0] limit);
      if (value >= limit) begin
         return limit;
      end
      return value + 4'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ram_arbiter_if.sv
// ============================================================================
// cpu_ram_arbiter_if : held-request memory bus (request/ack with byte mask)
// Revision 1.0
// ============================================================================
`default_nettype none

interface cpu_ram_arbiter_if;
   import cpu_ram_arbiter_pkg::*;

   logic              request;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wdata;
   logic [MASK_W-1:0] wmask;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (
      output request, address, wdata, wmask,
      input  ack, rdata
   );

   modport slave (
      input  request, address, wdata, wmask,
      output ack, rdata
   );

endinterface

`default_nettype wire

// File: rtl/cpu_ram_arbiter_mux.sv
// ============================================================================
// cpu_ram_arbiter_mux : owner-keyed request mux and ack/rdata demux
// Revision 1.0
// ============================================================================
`default_nettype none

module cpu_ram_arbiter_mux
   import cpu_ram_arbiter_pkg::*;
(
   input  e_ram_owner        owner_i,
   input  e_arb_state        state_i,
   cpu_ram_arbiter_if.slave  cpu_bus,
   cpu_ram_arbiter_if.slave  dma_bus,
   cpu_ram_arbiter_if.master ram_bus
);

   logic              w_sel_dma;
   logic              w_issue;
   logic              w_done;
   logic              w_cpu_ack;
   logic              w_dma_ack;
   logic [MASK_W-1:0] w_owner_wmask;

   assign w_sel_dma     = (owner_i == OWNER_DMA);
   assign w_issue       = (state_i == ARB_ISSUE);
   // A RAM ack only counts while a transfer is outstanding.
   assign w_done        = (state_i == ARB_WAIT) && ram_bus.ack;
   assign w_owner_wmask = w_sel_dma ? dma_bus.wmask : cpu_bus.wmask;

   assign ram_bus.request = w_issue;
   assign ram_bus.address = w_sel_dma ? dma_bus.address : cpu_bus.address;
   assign ram_bus.wdata   = w_sel_dma ? dma_bus.wdata   : cpu_bus.wdata;
   assign ram_bus.wmask   = w_issue ? w_owner_wmask : '0;

   assign w_cpu_ack = w_done && !w_sel_dma;
   assign w_dma_ack = w_done &&  w_sel_dma;

   assign cpu_bus.ack   = w_cpu_ack;
   assign cpu_bus.rdata = w_cpu_ack ? ram_bus.rdata : '0;
   assign dma_bus.ack   = w_dma_ack;
   assign dma_bus.rdata = w_dma_ack ? ram_bus.rdata : '0;

endmodule

`default_nettype wire

// File: rtl/cpu_ram_arbiter.sv
// ============================================================================
// cpu_ram_arbiter : weighted round-robin CPU/DMA arbiter for a single-port RAM
// Revision 1.0
// ============================================================================
`default_nettype none

module cpu_ram_arbiter
   import cpu_ram_arbiter_pkg::*;
#(
   parameter int DMA_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   cpu_ram_arbiter_if.slave  cpu_bus,
   cpu_ram_arbiter_if.slave  dma_bus,
   cpu_ram_arbiter_if.master ram_bus
);

   localparam logic [CNT_W-1:0] c_BURST = CNT_W'(DMA_BURST);

   e_arb_state       state_q;
   e_arb_state       state_d;
   e_ram_owner       owner_q;
   e_ram_owner       owner_d;
   logic [CNT_W-1:0] dma_count_q;
   logic [CNT_W-1:0] dma_count_d;
   logic             w_grant_cpu;
   logic             w_grant_dma;

   // DMA wins contention until it has used its burst allowance.
   always_comb begin
      w_grant_cpu = 1'b0;
      w_grant_dma = 1'b0;
      if (state_q == ARB_IDLE) begin
         if (dma_bus.request && (!cpu_bus.request || (dma_count_q < c_BURST))) begin
            w_grant_dma = 1'b1;
         end else if (cpu_bus.request) begin
            w_grant_cpu = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      dma_count_d = dma_count_q;
      case (state_q)
         ARB_IDLE: begin
            if (w_grant_cpu) begin
               state_d     = ARB_ISSUE;
               owner_d     = OWNER_CPU;
               dma_count_d = '0;
            end else if (w_grant_dma) begin
               state_d     = ARB_ISSUE;
               owner_d     = OWNER_DMA;
               dma_count_d = sat_inc(dma_count_q, c_BURST);
            end
         end
         ARB_ISSUE: begin
            state_d = ARB_WAIT;
         end
         ARB_WAIT: begin
            if (ram_bus.ack) begin
               state_d = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Count starts saturated so the CPU takes the first contended grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         owner_q     <= OWNER_CPU;
         dma_count_q <= c_BURST;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         dma_count_q <= dma_count_d;
      end
   end

   cpu_ram_arbiter_mux u_mux (
      .owner_i (owner_q),
      .state_i (state_q),
      .cpu_bus (cpu_bus),
      .dma_bus (dma_bus),
      .ram_bus (ram_bus)
   );

endmodule

`default_nettype wire

// File: tb/tb_cpu_ram_arbiter.sv
// ============================================================================
// tb_cpu_ram_arbiter : self-checking bench for the CPU/DMA RAM arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cpu_ram_arbiter;
   import cpu_ram_arbiter_pkg::*;

   localparam int B0 = 4;
   localparam int B1 = 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cpu_ram_arbiter_if cpu0 ();
   cpu_ram_arbiter_if dma0 ();
   cpu_ram_arbiter_if ram0 ();
   cpu_ram_arbiter_if cpu1 ();
   cpu_ram_arbiter_if dma1 ();
   cpu_ram_arbiter_if ram1 ();

   cpu_ram_arbiter #(.DMA_BURST(B0)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .cpu_bus (cpu0),
      .dma_bus (dma0),
      .ram_bus (ram0)
   );

   cpu_ram_arbiter #(.DMA_BURST(B1)) u_dut1 (
      .clk     (clk),
      .rst     (rst),
      .cpu_bus (cpu1),
      .dma_bus (dma1),
      .ram_bus (ram1)
   );

   int        checks = 0;
   int        errors = 0;
   bit [31:0] ram_mem [0:255];
   bit [31:0] ref_mem [0:255];
   int        ram_delay = 0;
   bit        ram_spur  = 1'b0;
   bit        cpu_done;
   bit        dma_done;

   // RAM behind the B=4 arbiter: write on request, ack ram_delay cycles late.
   initial begin : ram_model0
      bit        pend;
      int        dly;
      int        idx;
      bit [31:0] rd;
      pend = 1'b0; dly = 0; rd = '0;
      ram0.ack = 1'b0; ram0.rdata = '0;
      forever begin
         @(negedge clk);
         if (ram0.request === 1'b1) begin
            idx = int'(ram0.address[9:2]);
            rd  = ram_mem[idx];
            for (int b = 0; b < 4; b++) begin
               if (ram0.wmask[b] === 1'b1) ram_mem[idx][8*b +: 8] = ram0.wdata[8*b +: 8];
            end
            pend = 1'b1;
            dly  = ram_delay;
         end
         @(posedge clk);
         #1;
         ram0.ack   = ram_spur;
         ram0.rdata = '0;
         if (pend) begin
            if (dly == 0) begin
               ram0.ack   = 1'b1;
               ram0.rdata = rd;
               pend       = 1'b0;
            end else begin
               dly--;
            end
         end
      end
   end

   initial begin : ram_model1
      bit pend1;
      pend1 = 1'b0;
      ram1.ack = 1'b0; ram1.rdata = '0;
      forever begin
         @(negedge clk);
         pend1 = (ram1.request === 1'b1);
         @(posedge clk);
         #1;
         ram1.ack   = pend1;
         ram1.rdata = pend1 ? 32'h1111_0000 : 32'h0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      cpu0.request = 1'b0; cpu0.address = '0; cpu0.wdata = '0; cpu0.wmask = '0;
      dma0.request = 1'b0; dma0.address = '0; dma0.wdata = '0; dma0.wmask = '0;
      cpu1.request = 1'b0; cpu1.address = '0; cpu1.wdata = '0; cpu1.wmask = '0;
      dma1.request = 1'b0; dma1.address = '0; dma1.wdata = '0; dma1.wmask = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_all();
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_all();
      cpu0.request = 1'b1;
      dma0.request = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (ram0.request !== 1'b0) begin
            errors++; $display("FAIL reset_ram_request got %b want 0", ram0.request);
         end
         checks++;
         if (ram0.wmask !== 4'd0) begin
            errors++; $display("FAIL reset_ram_wmask got %h want 0", ram0.wmask);
         end
         checks++;
         if (cpu0.ack !== 1'b0 || dma0.ack !== 1'b0) begin
            errors++; $display("FAIL reset_acks got cpu %b dma %b want 0 0", cpu0.ack, dma0.ack);
         end
         checks++;
         if (cpu0.rdata !== 32'h0 || dma0.rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got cpu %h dma %h want 0 0", cpu0.rdata, dma0.rdata);
         end
      end
      tick();
      idle_all();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_cpu_read();
      ram_mem[4] = 32'hDEAD_BEEF;
      tick();
      cpu0.request = 1'b1; cpu0.address = 32'h10; cpu0.wmask = 4'd0; cpu0.wdata = $urandom;
      @(negedge clk);
      checks++;
      if (ram0.request !== 1'b0) begin
         errors++; $display("FAIL cpu_read_early_request got %b want 0", ram0.request);
      end
      @(negedge clk);
      checks++;
      if (ram0.request !== 1'b1 || ram0.address !== 32'h10 || ram0.wmask !== 4'd0) begin
         errors++; $display("FAIL cpu_read_issue got req %b addr %h mask %h want 1 00000010 0",
                            ram0.request, ram0.address, ram0.wmask);
      end
      @(negedge clk);
      checks++;
      if (cpu0.ack !== 1'b1 || cpu0.rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL cpu_read_ack got ack %b data %h want 1 deadbeef", cpu0.ack, cpu0.rdata);
      end
      checks++;
      if (dma0.ack !== 1'b0 || dma0.rdata !== 32'h0 || ram0.request !== 1'b0) begin
         errors++; $display("FAIL cpu_read_side got dma_ack %b dma_rdata %h ram_req %b want 0 0 0",
                            dma0.ack, dma0.rdata, ram0.request);
      end
      tick();
      cpu0.request = 1'b0;
      @(negedge clk);
      checks++;
      if (cpu0.ack !== 1'b0 || cpu0.rdata !== 32'h0) begin
         errors++; $display("FAIL cpu_read_after got ack %b data %h want 0 0", cpu0.ack, cpu0.rdata);
      end
   endtask

   task automatic test_dma_write();
      ram_mem[8] = 32'h1122_3344;
      tick();
      dma0.request = 1'b1; dma0.address = 32'h20; dma0.wmask = 4'b0100; dma0.wdata = 32'h00AB_0000;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ram0.request !== 1'b1 || ram0.wmask !== 4'b0100 || ram0.wdata !== 32'h00AB_0000 ||
          ram0.address !== 32'h20) begin
         errors++; $display("FAIL dma_write_issue got req %b mask %h data %h addr %h want 1 4 00ab0000 00000020",
                            ram0.request, ram0.wmask, ram0.wdata, ram0.address);
      end
      @(negedge clk);
      checks++;
      if (ram0.wmask !== 4'd0 || ram0.address !== 32'h20) begin
         errors++; $display("FAIL dma_write_wait_bus got mask %h addr %h want 0 00000020", ram0.wmask, ram0.address);
      end
      checks++;
      if (dma0.ack !== 1'b1 || cpu0.ack !== 1'b0) begin
         errors++; $display("FAIL dma_write_ack got dma %b cpu %b want 1 0", dma0.ack, cpu0.ack);
      end
      tick();
      dma0.request = 1'b0;
      checks++;
      if (ram_mem[8] !== 32'h11AB_3344) begin
         errors++; $display("FAIL dma_write_data got %h want 11ab3344", ram_mem[8]);
      end
   endtask

   // Both DUTs see both sides requesting continuously from reset.
   task automatic test_back_to_back();
      int  n0, n1, last0, last1;
      bit  exp_dma;
      do_reset();
      cpu0.request = 1'b1; cpu0.address = 32'h100; dma0.request = 1'b1; dma0.address = 32'h200;
      cpu1.request = 1'b1; cpu1.address = 32'h100; dma1.request = 1'b1; dma1.address = 32'h200;
      n0 = 0; n1 = 0; last0 = 0; last1 = 0;
      for (int c = 0; c < 40 && (n0 < 6 || n1 < 6); c++) begin
         @(negedge clk);
         if (n0 < 6 && (cpu0.ack === 1'b1 || dma0.ack === 1'b1)) begin
            exp_dma = (n0 % (B0 + 1)) != 0;
            checks++;
            if (dma0.ack !== exp_dma || cpu0.ack !== !exp_dma) begin
               errors++; $display("FAIL b2b_burst4_grant %0d got cpu %b dma %b want dma %b", n0, cpu0.ack, dma0.ack, exp_dma);
            end
            checks++;
            if ((n0 == 0 && c != 2) || (n0 > 0 && c - last0 != 3)) begin
               errors++; $display("FAIL b2b_burst4_spacing %0d got cycle %0d prev %0d want gap 3", n0, c, last0);
            end
            last0 = c; n0++;
         end
         if (n1 < 6 && (cpu1.ack === 1'b1 || dma1.ack === 1'b1)) begin
            exp_dma = (n1 % (B1 + 1)) != 0;
            checks++;
            if (dma1.ack !== exp_dma || cpu1.ack !== !exp_dma) begin
               errors++; $display("FAIL b2b_burst1_grant %0d got cpu %b dma %b want dma %b", n1, cpu1.ack, dma1.ack, exp_dma);
            end
            checks++;
            if ((n1 == 0 && c != 2) || (n1 > 0 && c - last1 != 3)) begin
               errors++; $display("FAIL b2b_burst1_spacing %0d got cycle %0d prev %0d want gap 3", n1, c, last1);
            end
            last1 = c; n1++;
         end
      end
      checks++;
      if (n0 != 6 || n1 != 6) begin
         errors++; $display("FAIL b2b_count got %0d %0d want 6 6", n0, n1);
      end
      tick();
      idle_all();
      tick();
   endtask

   task automatic test_delayed();
      int nreq;
      ram_delay = 5;
      tick();
      cpu0.request = 1'b1; cpu0.address = 32'h40; cpu0.wmask = 4'd0;
      nreq = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (ram0.request === 1'b1) nreq++;
         checks++;
         if (cpu0.ack !== (c == 7)) begin
            errors++; $display("FAIL delayed_ack cycle %0d got %b want %b", c, cpu0.ack, (c == 7));
         end
         if (c == 7) begin
            checks++;
            if (ram0.ack !== 1'b1) begin
               errors++; $display("FAIL delayed_ack_align got ram_ack %b want 1", ram0.ack);
            end
            tick();
            cpu0.request = 1'b0;
         end
      end
      checks++;
      if (nreq != 1) begin
         errors++; $display("FAIL delayed_reissue got %0d requests want 1", nreq);
      end
      ram_delay = 0;
   endtask

   task automatic test_spurious();
      @(negedge clk);
      ram_spur = 1'b1;
      @(negedge clk);
      ram_spur = 1'b0;
      checks++;
      if (cpu0.ack !== 1'b0 || dma0.ack !== 1'b0 || ram0.request !== 1'b0) begin
         errors++; $display("FAIL spurious_idle got cpu %b dma %b req %b want 0 0 0", cpu0.ack, dma0.ack, ram0.request);
      end
      tick();
      cpu0.request = 1'b1; cpu0.address = 32'h44; cpu0.wmask = 4'd0;
      @(negedge clk);
      ram_spur = 1'b1;
      @(negedge clk);
      ram_spur = 1'b0;
      checks++;
      if (ram0.request !== 1'b1 || cpu0.ack !== 1'b0) begin
         errors++; $display("FAIL spurious_issue got req %b ack %b want 1 0", ram0.request, cpu0.ack);
      end
      @(negedge clk);
      checks++;
      if (cpu0.ack !== 1'b1) begin
         errors++; $display("FAIL spurious_real_ack got %b want 1", cpu0.ack);
      end
      tick();
      cpu0.request = 1'b0;
   endtask

   task automatic test_reset_wait();
      ram_delay = 4;
      tick();
      cpu0.request = 1'b1; cpu0.address = 32'h80; cpu0.wmask = 4'd0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      cpu0.request = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int c = 4; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (cpu0.ack !== 1'b0 || dma0.ack !== 1'b0 || ram0.request !== 1'b0) begin
            errors++; $display("FAIL reset_wait_quiet cycle %0d got cpu %b dma %b req %b want 0 0 0",
                               c, cpu0.ack, dma0.ack, ram0.request);
         end
      end
      ram_delay = 0;
      tick();
      cpu0.request = 1'b1; cpu0.address = 32'hC0; dma0.request = 1'b1; dma0.address = 32'hE0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ram0.request !== 1'b1 || ram0.address !== 32'hC0) begin
         errors++; $display("FAIL reset_wait_first_grant got req %b addr %h want 1 000000c0", ram0.request, ram0.address);
      end
      @(negedge clk);
      checks++;
      if (cpu0.ack !== 1'b1 || dma0.ack !== 1'b0) begin
         errors++; $display("FAIL reset_wait_first_ack got cpu %b dma %b want 1 0", cpu0.ack, dma0.ack);
      end
      tick();
      idle_all();
      tick();
   endtask

   task automatic drive_side(input bit is_dma, input int n);
      logic [31:0] a, d;
      logic [3:0]  m;
      bit          got;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         m = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         d = $urandom;
         if (is_dma) begin
            dma0.request = 1'b1; dma0.address = a; dma0.wmask = m; dma0.wdata = d;
         end else begin
            cpu0.request = 1'b1; cpu0.address = a; cpu0.wmask = m; cpu0.wdata = d;
         end
         got = 1'b0;
         for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if ((is_dma ? dma0.ack : cpu0.ack) === 1'b1) got = 1'b1;
         end
         checks++;
         if (!got) begin
            errors++; $display("FAIL rand_ack_timeout side %0d got no ack want ack", is_dma);
         end
         tick();
         if (is_dma) dma0.request = 1'b0;
         else        cpu0.request = 1'b0;
      end
   endtask

   // Reference: DMA wins contention while fewer than B DMA grants followed the last CPU grant.
   task automatic test_random();
      bit          due, pc, pd;
      e_ram_owner  who;
      logic [31:0] wa, wd, rd;
      logic [3:0]  wm;
      int          dma_run, idx, diffs;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = $urandom;
         ref_mem[i] = ram_mem[i];
      end
      cpu_done = 1'b0; dma_done = 1'b0;
      due = 1'b0; pc = 1'b0; pd = 1'b0; dma_run = 1000;
      who = OWNER_CPU; wa = '0; wd = '0; wm = '0;
      fork
         begin drive_side(1'b0, 30); cpu_done = 1'b1; end
         begin drive_side(1'b1, 30); dma_done = 1'b1; end
         begin
            for (int cyc = 0; cyc < 20000 && !(cpu_done && dma_done && !due); cyc++) begin
               @(negedge clk);
               checks++;
               if (cpu0.ack !== (due && who == OWNER_CPU) || dma0.ack !== (due && who == OWNER_DMA)) begin
                  errors++; $display("FAIL rand_ack cycle %0d got cpu %b dma %b want cpu %b dma %b", cyc,
                                     cpu0.ack, dma0.ack, (due && who == OWNER_CPU), (due && who == OWNER_DMA));
               end
               if (due) begin
                  idx = int'(wa[9:2]);
                  rd  = (who == OWNER_CPU) ? cpu0.rdata : dma0.rdata;
                  if (wm == 4'd0) begin
                     checks++;
                     if (rd !== ref_mem[idx]) begin
                        errors++; $display("FAIL rand_rdata addr %h got %h want %h", wa, rd, ref_mem[idx]);
                     end
                  end else begin
                     for (int b = 0; b < 4; b++) begin
                        if (wm[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                     end
                  end
                  checks++;
                  if (((who == OWNER_CPU) ? dma0.rdata : cpu0.rdata) !== 32'h0) begin
                     errors++; $display("FAIL rand_idle_rdata got %h want 0", (who == OWNER_CPU) ? dma0.rdata : cpu0.rdata);
                  end
               end
               due = 1'b0;
               if (ram0.request === 1'b1) begin
                  checks++;
                  if (!pc && !pd) begin
                     errors++; $display("FAIL rand_grant_no_request got grant want none");
                  end
                  who = (pd && (!pc || dma_run < B0)) ? OWNER_DMA : OWNER_CPU;
                  wa  = (who == OWNER_DMA) ? dma0.address : cpu0.address;
                  wd  = (who == OWNER_DMA) ? dma0.wdata   : cpu0.wdata;
                  wm  = (who == OWNER_DMA) ? dma0.wmask   : cpu0.wmask;
                  checks++;
                  if (ram0.address !== wa || ram0.wdata !== wd || ram0.wmask !== wm) begin
                     errors++; $display("FAIL rand_ram_bus owner %0d got %h %h %h want %h %h %h", who,
                                        ram0.address, ram0.wdata, ram0.wmask, wa, wd, wm);
                  end
                  dma_run = (who == OWNER_DMA) ? dma_run + 1 : 0;
                  due = 1'b1;
               end
               pc = (cpu0.request === 1'b1);
               pd = (dma0.request === 1'b1);
            end
         end
      join
      checks++;
      if (!(cpu_done && dma_done)) begin
         errors++; $display("FAIL rand_done got cpu %b dma %b want 1 1", cpu_done, dma_done);
      end
      diffs = 0;
      for (int i = 0; i < 256; i++) begin
         if (ram_mem[i] !== ref_mem[i]) diffs++;
      end
      checks++;
      if (diffs != 0) begin
         errors++; $display("FAIL rand_memory got %0d differing words want 0", diffs);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_all();
      test_reset();
      test_cpu_read();
      test_dma_write();
      test_back_to_back();
      test_delayed();
      test_spurious();
      test_reset_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
